// File: rtl/player_pkg.sv
`default_nettype none
// ============================================================================
// Module      : player_pkg
// Description : Shared types and constants for the multi-player position path.
// Revision    : 1.0 - initial release
// ============================================================================
package player_pkg;

    localparam int NUM_SRC = 3;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } dir_t;

    localparam int c_dir_w = $bits(dir_t);

    typedef enum logic [1:0] {
        SRC_SNES = 2'd0,
        SRC_IR   = 2'd1,
        SRC_PS2  = 2'd2,
        SRC_NONE = 2'd3
    } src_e;

endpackage
`default_nettype wire

// File: rtl/player_mover.sv
`default_nettype none
// ============================================================================
// Module      : player_mover
// Description : One player: source select, direction latch, and X/Y stepping
//               with clamp or wrap at the screen edges.
// Revision    : 1.0 - initial release
// ============================================================================
module player_mover
    import player_pkg::*;
#(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 9,
    parameter int X_MAX   = 639,
    parameter int Y_MAX   = 479,
    parameter int STEP    = 1,
    parameter int WRAP    = 0,
    parameter int X_INIT  = 0,
    parameter int Y_INIT  = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   i_choice,
    input  logic [NUM_SRC*c_dir_w-1:0]   i_src_dir,
    input  logic [NUM_SRC-1:0]           i_src_readable,
    input  logic                         i_move,
    output logic [X_WIDTH-1:0]           o_x,
    output logic [Y_WIDTH-1:0]           o_y,
    output logic                         o_moved
);

    localparam logic [X_WIDTH-1:0] c_x_init    = X_WIDTH'(X_INIT);
    localparam logic [Y_WIDTH-1:0] c_y_init    = Y_WIDTH'(Y_INIT);
    localparam logic [X_WIDTH:0]   c_x_step    = (X_WIDTH+1)'(STEP);
    localparam logic [Y_WIDTH:0]   c_y_step    = (Y_WIDTH+1)'(STEP);
    localparam logic [X_WIDTH:0]   c_x_max     = (X_WIDTH+1)'(X_MAX);
    localparam logic [Y_WIDTH:0]   c_y_max     = (Y_WIDTH+1)'(Y_MAX);
    localparam logic [X_WIDTH:0]   c_x_wrap_dn = (X_WIDTH+1)'(X_MAX + 1 - STEP);
    localparam logic [Y_WIDTH:0]   c_y_wrap_dn = (Y_WIDTH+1)'(Y_MAX + 1 - STEP);
    localparam logic [X_WIDTH:0]   c_x_span    = (X_WIDTH+1)'(X_MAX + 1);
    localparam logic [Y_WIDTH:0]   c_y_span    = (Y_WIDTH+1)'(Y_MAX + 1);

    src_e               w_sel;
    src_e               r_choice;
    dir_t               r_dir;
    dir_t               w_sel_dir;
    logic               w_sel_rdy;
    logic [X_WIDTH-1:0] r_x;
    logic [Y_WIDTH-1:0] r_y;
    logic               r_moved;

    logic [X_WIDTH:0]   w_x_ext, w_x_dec, w_x_inc, w_x_wrap_dn, w_x_wrap_up;
    logic [Y_WIDTH:0]   w_y_ext, w_y_dec, w_y_inc, w_y_wrap_dn, w_y_wrap_up;
    logic [X_WIDTH-1:0] w_x_next;
    logic [Y_WIDTH-1:0] w_y_next;

    assign w_sel = src_e'(i_choice);

    // SRC_NONE matches no source index, so it yields a zero direction and no strobe
    always_comb begin
        w_sel_dir = '0;
        w_sel_rdy = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (i_choice == 2'(s)) begin
                w_sel_dir = dir_t'(i_src_dir[s*c_dir_w +: c_dir_w]);
                w_sel_rdy = i_src_readable[s];
            end
        end
    end

    // The extra top bit flags a borrow on decrement; increment overflow is a compare
    assign w_x_ext     = {1'b0, r_x};
    assign w_x_dec     = w_x_ext - c_x_step;
    assign w_x_inc     = w_x_ext + c_x_step;
    assign w_x_wrap_dn = w_x_ext + c_x_wrap_dn;
    assign w_x_wrap_up = w_x_inc - c_x_span;

    assign w_y_ext     = {1'b0, r_y};
    assign w_y_dec     = w_y_ext - c_y_step;
    assign w_y_inc     = w_y_ext + c_y_step;
    assign w_y_wrap_dn = w_y_ext + c_y_wrap_dn;
    assign w_y_wrap_up = w_y_inc - c_y_span;

    always_comb begin
        w_x_next = r_x;
        if (r_dir.left && !r_dir.right) begin
            if (w_x_dec[X_WIDTH]) begin
                if (WRAP != 0) w_x_next = w_x_wrap_dn[X_WIDTH-1:0];
                else           w_x_next = '0;
            end else begin
                w_x_next = w_x_dec[X_WIDTH-1:0];
            end
        end else if (r_dir.right && !r_dir.left) begin
            if (w_x_inc > c_x_max) begin
                if (WRAP != 0) w_x_next = w_x_wrap_up[X_WIDTH-1:0];
                else           w_x_next = c_x_max[X_WIDTH-1:0];
            end else begin
                w_x_next = w_x_inc[X_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_y_next = r_y;
        if (r_dir.up && !r_dir.down) begin
            if (w_y_dec[Y_WIDTH]) begin
                if (WRAP != 0) w_y_next = w_y_wrap_dn[Y_WIDTH-1:0];
                else           w_y_next = '0;
            end else begin
                w_y_next = w_y_dec[Y_WIDTH-1:0];
            end
        end else if (r_dir.down && !r_dir.up) begin
            if (w_y_inc > c_y_max) begin
                if (WRAP != 0) w_y_next = w_y_wrap_up[Y_WIDTH-1:0];
                else           w_y_next = c_y_max[Y_WIDTH-1:0];
            end else begin
                w_y_next = w_y_inc[Y_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Capturing the live select avoids a spurious change-clear after reset
            r_choice <= w_sel;
            r_dir    <= '0;
            r_x      <= c_x_init;
            r_y      <= c_y_init;
            r_moved  <= 1'b0;
        end else begin
            r_choice <= w_sel;
            if (w_sel != r_choice || w_sel == SRC_NONE) begin
                r_dir <= '0;
            end else if (w_sel_rdy) begin
                r_dir <= w_sel_dir;
            end
            r_moved <= 1'b0;
            if (i_move) begin
                r_x     <= w_x_next;
                r_y     <= w_y_next;
                r_moved <= (w_x_next != r_x) || (w_y_next != r_y);
            end
        end
    end

    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_moved = r_moved;

endmodule
`default_nettype wire

// File: rtl/multi_player_tracker.sv
`default_nettype none
// ============================================================================
// Module      : multi_player_tracker
// Description : Frame-tick divider plus one position mover per player.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_player_tracker
    import player_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int X_WIDTH     = 10,
    parameter int Y_WIDTH     = 9,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int STEP        = 1,
    parameter int TICK_DIV    = 833333,
    parameter int WRAP        = 0
) (
    input  logic                                   Clock,
    input  logic                                   Reset_n,
    input  logic [2*NUM_PLAYERS-1:0]               Choice,
    input  logic [NUM_PLAYERS*NUM_SRC*c_dir_w-1:0] SrcDir,
    input  logic [NUM_PLAYERS*NUM_SRC-1:0]         SrcReadable,
    input  logic                                   Freeze,
    output logic [NUM_PLAYERS*X_WIDTH-1:0]         X,
    output logic [NUM_PLAYERS*Y_WIDTH-1:0]         Y,
    output logic [NUM_PLAYERS-1:0]                 Moved,
    output logic                                   Tick
);

    localparam int                 c_cnt_w    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic               r_tick;
    logic               w_move;

    assign w_cnt_next = (r_cnt == c_cnt_last) ? '0 : r_cnt + c_cnt_w'(1);

    // Tick is registered against the next count so it lines up with count == last
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_tick <= (w_cnt_next == c_cnt_last);
        end
    end

    assign Tick   = r_tick;
    assign w_move = r_tick & ~Freeze;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        localparam int c_x_init = (p + 1) * X_MAX / (NUM_PLAYERS + 1);
        localparam int c_y_init = Y_MAX / 2;

        player_mover #(
            .X_WIDTH (X_WIDTH),
            .Y_WIDTH (Y_WIDTH),
            .X_MAX   (X_MAX),
            .Y_MAX   (Y_MAX),
            .STEP    (STEP),
            .WRAP    (WRAP),
            .X_INIT  (c_x_init),
            .Y_INIT  (c_y_init)
        ) u_mover (
            .clk            (Clock),
            .rst_n          (Reset_n),
            .i_choice       (Choice[2*p +: 2]),
            .i_src_dir      (SrcDir[p*NUM_SRC*c_dir_w +: NUM_SRC*c_dir_w]),
            .i_src_readable (SrcReadable[p*NUM_SRC +: NUM_SRC]),
            .i_move         (w_move),
            .o_x            (X[p*X_WIDTH +: X_WIDTH]),
            .o_y            (Y[p*Y_WIDTH +: Y_WIDTH]),
            .o_moved        (Moved[p])
        );
    end

endmodule
`default_nettype wire

// File: doc/multi_player_tracker.md
# multi_player_tracker

Parametrised successor to the single-player input/position path. It takes decoded direction buttons from every controller source (SNES/NES, IR, PS/2) for `NUM_PLAYERS` players and selects one source per player at run time. It latches each player's direction on that source's `Readable` strobe and moves every player's on-screen position once per frame tick, with clamp or wrap at the screen edges. It sits between the controller front-ends and the renderer.

## Interface
Parameters:
- `NUM_PLAYERS`, 2: number of independent players (1..8).
- `X_WIDTH`, 10: width of the X coordinate.
- `Y_WIDTH`, 9: width of the Y coordinate.
- `X_MAX`, 639: largest legal X value.
- `Y_MAX`, 479: largest legal Y value.
- `STEP`, 1: pixels moved per tick. Must satisfy 1 ≤ STEP ≤ min(X_MAX, Y_MAX).
- `TICK_DIV`, 833333: Clock cycles per move tick (60 Hz at 50 MHz). Must be ≥ 2.
- `WRAP`, 0: edge behaviour. 0 = clamp, 1 = wrap.

Ports:
- `Clock`  in  1  system clock. Single clock domain.
- `Reset_n`  in  1  reset, synchronous, active-low.
- `Choice`  in  2·NUM_PLAYERS  per-player source select: 0 SNES, 1 IR, 2 PS/2, 3 disabled.
- `SrcDir`  in  NUM_PLAYERS·3·4  per player, per source: {Up, Down, Left, Right}.
- `SrcReadable`  in  NUM_PLAYERS·3  per player, per source: one-cycle pulse meaning SrcDir is valid.
- `Freeze`  in  1  pause. While high, no position changes occur.
- `X`  out  NUM_PLAYERS·X_WIDTH  per-player X position.
- `Y`  out  NUM_PLAYERS·Y_WIDTH  per-player Y position.
- `Moved`  out  NUM_PLAYERS  one-cycle pulse, high in the cycle a new position first appears on X/Y.
- `Tick`  out  1  one-cycle frame-tick pulse, exported for the renderer.

## Operation
Reset values (all outputs registered):
- Player p: X = (p+1)·X_MAX/(NUM_PLAYERS+1), integer division. Y = Y_MAX/2.
- Latched direction = 0, Moved = 0, Tick = 0, tick counter = 0.

Direction latch (per player):
- On a cycle where `SrcReadable[p][Choice[p]]` is high, latch `SrcDir[p][Choice[p]]`.
- Readable pulses from non-selected sources are ignored.
- Choice = 3: the latch is held at 0 and the player never moves.
- A change of Choice[p], detected against a registered copy, clears the latch on the next edge. This takes priority over a same-cycle Readable.

Tick divider:
- Counts 0..TICK_DIV-1, then wraps to 0.
- Tick is high for the one cycle where the count is TICK_DIV-1.
- The divider keeps running while Freeze is high.

Move (per player, on Tick with Freeze low):
- Up and Down both set: Y unchanged. Left and Right both set: X unchanged.
- Up: Y − STEP. Down: Y + STEP. Left: X − STEP. Right: X + STEP.
- Clamp (WRAP=0): results are held within 0..MAX. For example, Y=0 with Up stays 0, and X=X_MAX−1 with STEP=2 goes to X_MAX.
- Wrap (WRAP=1): results are taken modulo (MAX+1). If pos < STEP, pos−STEP becomes pos−STEP+MAX+1. If pos+STEP > MAX, pos+STEP becomes pos+STEP−MAX−1.
- Arithmetic uses one extra bit of width to detect overflow and underflow.
- Moved[p] = 1 only if X or Y actually changed. A clamp that leaves the position unchanged gives Moved = 0.

## Timing
- Readable at cycle n: the latch is updated at the edge ending cycle n.
- Tick at cycle t: the latch value held during t is used. New X/Y and Moved appear in cycle t+1, so latency is 1 cycle.
- Readable and Tick in the same cycle: the move uses the old latch, and the new value is latched for the next tick.
- Reset_n low in any cycle: all state returns to reset values at that edge, and any in-flight move is discarded.
- Freeze high during a Tick cycle: that tick is skipped, not deferred.

## Structure
- Package `player_pkg` holds:
  - `dir_t` packed struct {Up, Down, Left, Right}.
  - `src_e` enum SRC_SNES=0, SRC_IR=1, SRC_PS2=2, SRC_NONE=3.
  - `NUM_SRC`=3.
- Sub-module `player_mover`: one per player, generated. It contains the source mux, direction latch, choice-change detect, and the X/Y update with clamp/wrap.
- The top level holds the shared tick divider and Freeze gating.

## Test plan
Bench parameters for all scenarios: NUM_PLAYERS=2, X_MAX=Y_MAX=15, STEP=1, TICK_DIV=4.
1. Reset: X={5,10}, Y={7,7}, Moved=0. Tick pulses every 4th cycle.
2. P0 on SNES, Readable with Right, then 3 ticks: P0 X goes 5→8, Moved pulses 3 times. P1 X stays 10.
3. WRAP=0, P0 Up held: Y counts 7 down to 0 and stays 0. Moved=0 on ticks once Y=0. With WRAP=1: Y goes 0→15.
4. Both Up and Down plus Left: only X decrements. Readable on the Tick cycle takes effect on the following tick.
5. P1 on IR. An SNES Readable for P1 is ignored. Choice change to 3 clears the latch, and no moves follow.
6. Freeze high for 2 ticks: no moves, Tick still pulses. Reset_n low mid-run returns all players to (5,7) and (10,7).
